// File: rtl/pipe_ctrl_if.sv
// Handshake, hazard and buffer-control bundle between the rv32 core and pipe_ctrl.
// master drives the requests; slave (the controller) returns enables, clears and occupancy.
interface pipe_ctrl_if #(
  parameter int NSTAGE = 5,
  parameter int MCW    = 4,
  parameter int FW     = $clog2(NSTAGE)
);
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [NSTAGE-1:0] stall_req;
  logic              flush_req;
  logic [FW-1:0]     flush_stage;
  logic              mc_start;
  logic [MCW-1:0]    mc_cycles;
  logic [NSTAGE-1:0] en;
  logic [NSTAGE-1:0] stage_rst_n;
  logic [NSTAGE-1:0] valid;

  modport master (
    output in_valid, out_ready, stall_req, flush_req, flush_stage, mc_start, mc_cycles,
    input  in_ready, out_valid, en, stage_rst_n, valid
  );

  modport slave (
    input  in_valid, out_ready, stall_req, flush_req, flush_stage, mc_start, mc_cycles,
    output in_ready, out_valid, en, stage_rst_n, valid
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Occupancy tracker and load-enable / per-stage-clear generator for an rbuffer chain.
// Stage NSTAGE-1 is the entry (youngest) stage, stage 0 the exit (oldest) stage.
module pipe_ctrl #(
  parameter int NSTAGE   = 5,
  parameter int MC_STAGE = 2,
  parameter int MCW      = 4,
  parameter int FW       = $clog2(NSTAGE)
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
);

  logic [NSTAGE-1:0] valid_q, valid_d;
  logic [NSTAGE-1:0] fl_q, fl_d;
  logic [MCW-1:0]    mc_cnt_q, mc_cnt_d;

  logic [NSTAGE-1:0] kill;
  logic [NSTAGE-1:0] blk;
  logic [NSTAGE-1:0] hold;
  logic [NSTAGE-1:0] en_core;
  logic [NSTAGE-1:0] upstream;
  logic              mc_busy;
  logic              mc_accept;

  assign mc_busy = (mc_cnt_q != '0);

  for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
    assign kill[gi] = bus.flush_req & (bus.flush_stage <= FW'(gi));

    if (gi == MC_STAGE) begin : g_mc
      assign blk[gi] = bus.stall_req[gi] | mc_busy | fl_q[gi];
    end else begin : g_plain
      assign blk[gi] = bus.stall_req[gi] | fl_q[gi];
    end

    // Backpressure ripples from the exit stage towards the entry stage.
    if (gi == 0) begin : g_exit
      assign hold[gi] = valid_q[gi] & (blk[gi] | ~bus.out_ready);
    end else begin : g_chain
      assign hold[gi] = valid_q[gi] & (blk[gi] | hold[gi-1]);
    end

    assign en_core[gi] = ~hold[gi] & ~fl_q[gi] & ~kill[gi];

    if (gi == NSTAGE - 1) begin : g_entry
      assign upstream[gi] = bus.in_valid;
    end else begin : g_mid
      assign upstream[gi] = valid_q[gi+1] & en_core[gi+1];
    end

    assign valid_d[gi] = kill[gi]    ? 1'b0 :
                         en_core[gi] ? upstream[gi] : valid_q[gi];
  end

  assign fl_d      = kill;
  assign mc_accept = bus.mc_start & valid_q[MC_STAGE] & ~mc_busy & ~kill[MC_STAGE];

  always_comb begin
    mc_cnt_d = mc_cnt_q;
    if (kill[MC_STAGE]) begin
      mc_cnt_d = '0;
    end else if (mc_accept) begin
      mc_cnt_d = bus.mc_cycles;
    end else if (mc_busy) begin
      mc_cnt_d = mc_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      fl_q     <= '0;
      mc_cnt_q <= '0;
    end else begin
      valid_q  <= valid_d;
      fl_q     <= fl_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  // While reset is asserted every buffer is held clear and left enabled.
  assign bus.en          = en_core | {NSTAGE{~rst_n}};
  assign bus.in_ready    = bus.en[NSTAGE-1];
  assign bus.out_valid   = valid_q[0] & ~blk[0];
  assign bus.stage_rst_n = {NSTAGE{rst_n}} & ~fl_q;
  assign bus.valid       = valid_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven check of pipe_ctrl: streaming, backpressure, stalls, flush,
// multicycle hold, and an asynchronous reset in the middle of a stream.
module tb_pipe_ctrl;

  localparam int NSTAGE = 5;
  localparam int MCW    = 4;
  localparam int FW     = 3;

  typedef struct {
    logic       iv;
    logic       ordy;
    logic [4:0] stall;
    logic       fl;
    logic [2:0] fs;
    logic       mcs;
    logic [3:0] mcc;
    logic [4:0] e_valid;
    logic [4:0] e_en;
    logic [4:0] e_srst;
    logic       e_ir;
    logic       e_ov;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t vt[$];

  pipe_ctrl_if #(.NSTAGE(NSTAGE), .MCW(MCW), .FW(FW)) bus ();

  pipe_ctrl #(.NSTAGE(NSTAGE), .MC_STAGE(2), .MCW(MCW), .FW(FW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic ordy, input logic [4:0] stall,
                              input logic fl, input logic [2:0] fs, input logic mcs,
                              input logic [3:0] mcc, input logic [4:0] e_valid,
                              input logic [4:0] e_en, input logic [4:0] e_srst,
                              input logic e_ir, input logic e_ov);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.stall = stall; v.fl = fl; v.fs = fs;
    v.mcs = mcs; v.mcc = mcc; v.e_valid = e_valid; v.e_en = e_en;
    v.e_srst = e_srst; v.e_ir = e_ir; v.e_ov = e_ov;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic ordy, input logic [4:0] stall,
                       input logic fl, input logic [2:0] fs, input logic mcs,
                       input logic [3:0] mcc);
    bus.in_valid    = iv;
    bus.out_ready   = ordy;
    bus.stall_req   = stall;
    bus.flush_req   = fl;
    bus.flush_stage = fs;
    bus.mc_start    = mcs;
    bus.mc_cycles   = mcc;
  endtask

  initial begin
    int lat;
    drive(1'b0, 1'b0, 5'b0, 1'b0, 3'd0, 1'b0, 4'd0);

    //            iv ordy stall    fl fs  mcs mcc | valid     en        srst      ir ov
    // streaming fill
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b00000, 5'b11111, 5'b11111, 1, 0));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b10000, 5'b11111, 5'b11111, 1, 0));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b11000, 5'b11111, 5'b11111, 1, 0));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b11100, 5'b11111, 5'b11111, 1, 0));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b11110, 5'b11111, 5'b11111, 1, 0));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b11111, 5'b11111, 5'b11111, 1, 1));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b11111, 5'b11111, 5'b11111, 1, 1));
    // backpressure for three cycles
    vt.push_back(mk(1, 0, 5'b00000, 0, 0, 0, 0, 5'b11111, 5'b00000, 5'b11111, 0, 1));
    vt.push_back(mk(1, 0, 5'b00000, 0, 0, 0, 0, 5'b11111, 5'b00000, 5'b11111, 0, 1));
    vt.push_back(mk(1, 0, 5'b00000, 0, 0, 0, 0, 5'b11111, 5'b00000, 5'b11111, 0, 1));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b11111, 5'b11111, 5'b11111, 1, 1));
    // single-cycle stall on stage 2 leaves a bubble in stage 1
    vt.push_back(mk(1, 1, 5'b00100, 0, 0, 0, 0, 5'b11111, 5'b00011, 5'b11111, 0, 1));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b11101, 5'b11111, 5'b11111, 1, 1));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b11110, 5'b11111, 5'b11111, 1, 0));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b11111, 5'b11111, 5'b11111, 1, 1));
    // flush from stage 3 upward, then refill
    vt.push_back(mk(1, 1, 5'b00000, 1, 3, 0, 0, 5'b11111, 5'b00111, 5'b11111, 0, 1));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b00011, 5'b00111, 5'b00111, 0, 1));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b00001, 5'b11111, 5'b11111, 1, 1));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b10000, 5'b11111, 5'b11111, 1, 0));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b11000, 5'b11111, 5'b11111, 1, 0));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b11100, 5'b11111, 5'b11111, 1, 0));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b11110, 5'b11111, 5'b11111, 1, 0));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b11111, 5'b11111, 5'b11111, 1, 1));
    // 3-cycle multicycle hold; a restart with 9 mid-hold must be ignored
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 1, 3, 5'b11111, 5'b11111, 5'b11111, 1, 1));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b11111, 5'b00011, 5'b11111, 0, 1));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 1, 9, 5'b11101, 5'b00011, 5'b11111, 0, 1));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b11100, 5'b00011, 5'b11111, 0, 0));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b11100, 5'b11111, 5'b11111, 1, 0));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b11110, 5'b11111, 5'b11111, 1, 0));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b11111, 5'b11111, 5'b11111, 1, 1));
    // flush from stage 1 in the same cycle as mc_start: the start is dropped
    vt.push_back(mk(1, 1, 5'b00000, 1, 1, 1, 5, 5'b11111, 5'b00001, 5'b11111, 0, 1));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b00000, 5'b00001, 5'b00001, 0, 0));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b00000, 5'b11111, 5'b11111, 1, 0));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b10000, 5'b11111, 5'b11111, 1, 0));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b11000, 5'b11111, 5'b11111, 1, 0));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b11100, 5'b11111, 5'b11111, 1, 0));
    // mc_cycles = 0 means no hold
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 1, 0, 5'b11110, 5'b11111, 5'b11111, 1, 0));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b11111, 5'b11111, 5'b11111, 1, 1));
    // exit-stage stall masks out_valid and freezes the whole pipe
    vt.push_back(mk(1, 1, 5'b00001, 0, 0, 0, 0, 5'b11111, 5'b00000, 5'b11111, 0, 0));
    vt.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 5'b11111, 5'b11111, 5'b11111, 1, 1));

    // reset state
    #3;
    chk("rst_valid", 32'(bus.valid), 32'h00);
    chk("rst_en", 32'(bus.en), 32'h1f);
    chk("rst_srst", 32'(bus.stage_rst_n), 32'h00);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      drive(vt[i].iv, vt[i].ordy, vt[i].stall, vt[i].fl, vt[i].fs, vt[i].mcs, vt[i].mcc);
      #1;
      chk($sformatf("v%0d_valid", i), 32'(bus.valid), 32'(vt[i].e_valid));
      chk($sformatf("v%0d_en", i), 32'(bus.en), 32'(vt[i].e_en));
      chk($sformatf("v%0d_srst", i), 32'(bus.stage_rst_n), 32'(vt[i].e_srst));
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(vt[i].e_ir));
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vt[i].e_ov));
      $display("vec %0d: valid=%b en=%b srst=%b in_ready=%b out_valid=%b", i,
               bus.valid, bus.en, bus.stage_rst_n, bus.in_ready, bus.out_valid);
    end

    // asynchronous reset between clock edges while the pipe is full
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(bus.valid), 32'h00);
    chk("async_srst", 32'(bus.stage_rst_n), 32'h00);
    chk("async_out_valid", 32'(bus.out_valid), 32'h0);
    chk("async_en", 32'(bus.en), 32'h1f);
    chk("async_in_ready", 32'(bus.in_ready), 32'h1);
    $display("async reset: valid=%b srst=%b out_valid=%b", bus.valid, bus.stage_rst_n,
             bus.out_valid);

    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 5'b0, 1'b0, 3'd0, 1'b0, 4'd0);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) begin
        lat = n;
        break;
      end
    end
    chk("post_rst_latency", 32'(lat), 32'd5);
    chk("post_rst_valid", 32'(bus.valid), 32'h1f);
    $display("post-reset: first out_valid after %0d edges, valid=%b", lat, bus.valid);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
